commit_trace_buffer: RTL and testbench

//  Captures architectural commit events (GRF writes, DM writes) from the mips core and queues them.

---
 rtl/trace_pkg.sv | 41 ++++
 rtl/commit_trace_buffer_if.sv | 47 ++++
 rtl/trace_fifo2w.sv | 64 ++++++
 rtl/commit_trace_buffer.sv | 92 +++++++++
 tb/tb_commit_trace_buffer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the commit trace path.
//   KIND_GRF / KIND_DM : event kind tags carried in trace entries
//   PC_RESET           : reset PC of the mips core, used to build trace PCs
//   trace_entry_t      : one queued commit event (97 bits)
package trace_pkg;

  localparam logic        KIND_GRF = 1'b0;
  localparam logic        KIND_DM  = 1'b1;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

  // GRF destinations are widened to a full address so both kinds share one layout
  function automatic trace_entry_t make_grf_entry(input logic [31:0] pc,
                                                  input logic [4:0]  rd,
                                                  input logic [31:0] data);
    trace_entry_t e;
    e.kind = KIND_GRF;
    e.pc   = pc;
    e.addr = {27'b0, rd};
    e.data = data;
    return e;
  endfunction

  function automatic trace_entry_t make_dm_entry(input logic [31:0] pc,
                                                 input logic [31:0] addr,
                                                 input logic [31:0] data);
    trace_entry_t e;
    e.kind = KIND_DM;
    e.pc   = pc;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Commit-event and trace-drain bundle around commit_trace_buffer.
//   grf_* / dm_*            : commit events from the core (into the buffer)
//   out_valid/out_ready     : drain handshake toward the trace sink
//   out_kind/pc/addr/data   : head event presented to the sink
//   level/overflow/drop_cnt : occupancy and drop status
// master: core/sink side; slave: the buffer.
interface commit_trace_buffer_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DROP_W = 8
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              grf_we;
  logic [31:0]       grf_pc;
  logic [4:0]        grf_addr;
  logic [31:0]       grf_wdata;
  logic              dm_we;
  logic [31:0]       dm_pc;
  logic [31:0]       dm_addr;
  logic [31:0]       dm_wdata;
  logic              out_valid;
  logic              out_ready;
  logic              out_kind;
  logic [31:0]       out_pc;
  logic [31:0]       out_addr;
  logic [31:0]       out_data;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output grf_we, grf_pc, grf_addr, grf_wdata,
    output dm_we, dm_pc, dm_addr, dm_wdata,
    output out_ready,
    input  out_valid, out_kind, out_pc, out_addr, out_data,
    input  level, overflow, drop_cnt
  );

  modport slave (
    input  grf_we, grf_pc, grf_addr, grf_wdata,
    input  dm_we, dm_pc, dm_addr, dm_wdata,
    input  out_ready,
    output out_valid, out_kind, out_pc, out_addr, out_data,
    output level, overflow, drop_cnt
  );

endinterface

// File: rtl/trace_fifo2w.sv
// DEPTH-entry trace queue with two in-order write ports and one FWFT read port.
//   clk, reset         : clock, synchronous active-high reset (clears pointers)
//   wr0_en/wr0_data    : first write of the cycle
//   wr1_en/wr1_data    : second write; lands after wr0 when both are enabled
//   rd_en              : advance head (caller guarantees non-empty)
//   rd_data            : head entry, read from registered storage
//   level              : occupancy, 0..DEPTH
// Caller guarantees writes never exceed free space.
module trace_fifo2w
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr0_en,
  input  trace_entry_t                wr0_data,
  input  logic                        wr1_en,
  input  trace_entry_t                wr1_data,
  input  logic                        rd_en,
  output trace_entry_t                rd_data,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  trace_entry_t    mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [AW-1:0]   wr0_idx;
  logic [AW-1:0]   wr1_idx;

  // Second write slot follows the first only if the first is actually used
  always_comb begin
    wr0_idx = wptr[AW-1:0];
    wr1_idx = wptr[AW-1:0] + AW'(wr0_en);
  end

  // Storage has no reset; contents are don't-care while pointers are cleared
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr0_en) mem[wr0_idx] <= wr0_data;
      if (wr1_en) mem[wr1_idx] <= wr1_data;
    end
  end

  // Pointers carry one extra MSB so full and empty differ
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + PW'(wr0_en) + PW'(wr1_en);
      rptr <= rptr + PW'(rd_en);
    end
  end

  always_comb begin
    level   = wptr - rptr;
    rd_data = mem[rptr[AW-1:0]];
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: queues GRF/DM commit events from the core and drains
// them one per handshake to a trace sink, counting events lost to overflow.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : commit_trace_buffer_if.slave (commit inputs, drain handshake, status)
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FILTER_R0 = 1,
  parameter int unsigned DROP_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  commit_trace_buffer_if.slave   bus
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic               grf_q;
  logic               grf_ok;
  logic               dm_ok;
  logic [LVL_W-1:0]   level;
  logic [LVL_W-1:0]   free_c;
  logic [1:0]         n_drop;
  logic               pop;
  logic               head_valid;
  trace_entry_t       grf_entry;
  trace_entry_t       dm_entry;
  trace_entry_t       head;
  logic [DROP_W:0]    drop_sum;
  logic [DROP_W-1:0]  drop_next;
  logic               overflow_q;
  logic [DROP_W-1:0]  drop_cnt_q;

  // Qualify and admit events; free space comes from start-of-cycle level only
  always_comb begin
    grf_q     = bus.grf_we && !((FILTER_R0 != 0) && (bus.grf_addr == 5'd0));
    free_c    = LVL_W'(DEPTH) - level;
    grf_ok    = grf_q && (free_c != '0);
    dm_ok     = bus.dm_we && (free_c > (grf_ok ? LVL_W'(1) : LVL_W'(0)));
    n_drop    = 2'(grf_q && !grf_ok) + 2'(bus.dm_we && !dm_ok);
    grf_entry = make_grf_entry(bus.grf_pc, bus.grf_addr, bus.grf_wdata);
    dm_entry  = make_dm_entry(bus.dm_pc, bus.dm_addr, bus.dm_wdata);
  end

  always_comb begin
    head_valid = (level != '0);
    pop        = head_valid && bus.out_ready;
  end

  trace_fifo2w #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr0_en   (grf_ok),
    .wr0_data (grf_entry),
    .wr1_en   (dm_ok),
    .wr1_data (dm_entry),
    .rd_en    (pop),
    .rd_data  (head),
    .level    (level)
  );

  // Saturating drop accumulator
  always_comb begin
    drop_sum  = {1'b0, drop_cnt_q} + (DROP_W+1)'(n_drop);
    drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (n_drop != 2'd0) begin
      overflow_q <= 1'b1;
      drop_cnt_q <= drop_next;
    end
  end

  // Payload is zeroed when nothing is presented so reset leaves all outputs at 0
  always_comb begin
    bus.out_valid = head_valid;
    bus.out_kind  = head_valid ? head.kind : 1'b0;
    bus.out_pc    = head_valid ? head.pc   : '0;
    bus.out_addr  = head_valid ? head.addr : '0;
    bus.out_data  = head_valid ? head.data : '0;
    bus.level     = level;
    bus.overflow  = overflow_q;
    bus.drop_cnt  = drop_cnt_q;
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed self-checking bench for commit_trace_buffer (DEPTH=16, FILTER_R0=1).
module tb_commit_trace_buffer;
  import trace_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DROP_W = 8;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  commit_trace_buffer_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

  commit_trace_buffer #(.DEPTH(DEPTH), .FILTER_R0(1), .DROP_W(DROP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.grf_we    = 1'b0;
    bus.grf_pc    = '0;
    bus.grf_addr  = '0;
    bus.grf_wdata = '0;
    bus.dm_we     = 1'b0;
    bus.dm_pc     = '0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
  endtask

  task automatic drive_grf(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] d);
    bus.grf_we    = 1'b1;
    bus.grf_pc    = pc;
    bus.grf_addr  = rd;
    bus.grf_wdata = d;
  endtask

  task automatic drive_dm(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
    bus.dm_we    = 1'b1;
    bus.dm_pc    = pc;
    bus.dm_addr  = a;
    bus.dm_wdata = d;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle_inputs();
    bus.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_drop", 32'(bus.drop_cnt), 32'd0);
    check("rst_data", bus.out_data, 32'd0);

    // 1: single GRF event, sink ready
    bus.out_ready = 1'b1;
    drive_grf(PC_RESET, 5'd5, 32'h1234);
    tick();
    idle_inputs();
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_kind", 32'(bus.out_kind), 32'd0);
    check("t1_pc", bus.out_pc, 32'h3000);
    check("t1_addr", bus.out_addr, 32'd5);
    check("t1_data", bus.out_data, 32'h1234);
    check("t1_level", 32'(bus.level), 32'd1);
    tick();
    check("t1_level_after", 32'(bus.level), 32'd0);
    check("t1_valid_after", 32'(bus.out_valid), 32'd0);

    // 2: GRF and DM in the same cycle drain GRF first
    bus.out_ready = 1'b0;
    drive_grf(32'h3004, 5'd3, 32'd7);
    drive_dm(32'h3004, 32'h10, 32'd9);
    tick();
    idle_inputs();
    check("t2_level", 32'(bus.level), 32'd2);
    check("t2_b0_kind", 32'(bus.out_kind), 32'd0);
    check("t2_b0_addr", bus.out_addr, 32'd3);
    check("t2_b0_data", bus.out_data, 32'd7);
    tick();
    check("t2_stall_data", bus.out_data, 32'd7);
    bus.out_ready = 1'b1;
    tick();
    check("t2_b1_kind", 32'(bus.out_kind), 32'd1);
    check("t2_b1_pc", bus.out_pc, 32'h3004);
    check("t2_b1_addr", bus.out_addr, 32'h10);
    check("t2_b1_data", bus.out_data, 32'd9);
    check("t2_level1", 32'(bus.level), 32'd1);
    tick();
    check("t2_level0", 32'(bus.level), 32'd0);
    bus.out_ready = 1'b0;

    // 4: GRF write to $0 is filtered, not dropped
    drive_grf(32'h3008, 5'd0, 32'hff);
    tick();
    idle_inputs();
    check("t4_level", 32'(bus.level), 32'd0);
    check("t4_drop", 32'(bus.drop_cnt), 32'd0);
    check("t4_valid", 32'(bus.out_valid), 32'd0);

    // 3: DEPTH+3 pushes with sink stalled, then drain in order
    for (int i = 0; i < int'(DEPTH) + 3; i++) begin
      drive_grf(PC_RESET + 32'(4 * i), 5'((i % 31) + 1), 32'h100 + 32'(i));
      tick();
    end
    idle_inputs();
    check("t3_level", 32'(bus.level), 32'(DEPTH));
    check("t3_drop", 32'(bus.drop_cnt), 32'd3);
    check("t3_ovf", 32'(bus.overflow), 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      check("t3_drain_valid", 32'(bus.out_valid), 32'd1);
      check("t3_drain_data", bus.out_data, 32'h100 + 32'(i));
      tick();
    end
    check("t3_empty", 32'(bus.level), 32'd0);

    // 5: level DEPTH-1, both events plus a pop: GRF kept, DM dropped
    bus.out_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      drive_grf(32'h4000 + 32'(4 * i), 5'd1, 32'h200 + 32'(i));
      tick();
    end
    idle_inputs();
    check("t5_pre_level", 32'(bus.level), 32'(DEPTH - 1));
    bus.out_ready = 1'b1;
    drive_grf(32'h5000, 5'd7, 32'haaa);
    drive_dm(32'h5000, 32'h20, 32'hbbb);
    tick();
    idle_inputs();
    check("t5_level", 32'(bus.level), 32'(DEPTH - 1));
    check("t5_drop", 32'(bus.drop_cnt), 32'd4);
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      check("t5_drain_data", bus.out_data,
            (i < int'(DEPTH) - 2) ? 32'h201 + 32'(i) : 32'haaa);
      tick();
    end
    check("t5_empty", 32'(bus.level), 32'd0);

    // 6: reset mid-drain with level 5 and a concurrent push
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_dm(32'h6000, 32'(4 * i), 32'h600 + 32'(i));
      tick();
    end
    check("t6_level5", 32'(bus.level), 32'd5);
    bus.out_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    check("t6_valid", 32'(bus.out_valid), 32'd0);
    check("t6_level", 32'(bus.level), 32'd0);
    check("t6_ovf", 32'(bus.overflow), 32'd0);
    check("t6_drop", 32'(bus.drop_cnt), 32'd0);

    // 6b: continuous push/pop across three pointer wraps
    for (int i = 0; i < 3 * int'(DEPTH); i++) begin
      idle_inputs();
      if ((i % 2) == 1) drive_dm(32'h7000 + 32'(4 * i), 32'(4 * i), 32'h300 + 32'(i));
      else              drive_grf(32'h7000 + 32'(4 * i), 5'd9, 32'h300 + 32'(i));
      tick();
      check("t6_wrap_data", bus.out_data, 32'h300 + 32'(i));
      check("t6_wrap_kind", 32'(bus.out_kind), 32'(i % 2));
      check("t6_wrap_level", 32'(bus.level), 32'd1);
    end
    idle_inputs();
    tick();
    check("t6_wrap_empty", 32'(bus.level), 32'd0);
    check("t6_wrap_drop", 32'(bus.drop_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
